// File: rtl/bnn_conv_sequencer_if.sv
// Control/memory bus of the BNN convolution sequencer.
// The master side is the sequencer and the slave side is the host/memory environment.
interface bnn_conv_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] cfg_rows;
  logic [ADDR_W-1:0] cfg_cols;
  logic              in_valid;
  logic              in_ready;
  logic              inmem_en;
  logic              inmem_rw;
  logic [ADDR_W-1:0] inmem_row;
  logic [ADDR_W-1:0] inmem_col;
  logic              buffer_en;
  logic              outmem_en;
  logic              outmem_rw;
  logic [ADDR_W-1:0] outmem_row;
  logic [ADDR_W-1:0] outmem_col;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, cfg_rows, cfg_cols, in_valid, rd_en, rd_row, rd_col,
    output in_ready, inmem_en, inmem_rw, inmem_row, inmem_col, buffer_en,
           outmem_en, outmem_rw, outmem_row, outmem_col, busy, done, err
  );

  modport slave (
    output start, cfg_rows, cfg_cols, in_valid, rd_en, rd_row, rd_col,
    input  in_ready, inmem_en, inmem_rw, inmem_row, inmem_col, buffer_en,
           outmem_en, outmem_rw, outmem_row, outmem_col, busy, done, err
  );
endinterface

// File: rtl/bnn_conv_sequencer.sv
// Sequencer for a K x K binary convolution: loads an image bit-serially, sweeps
// K-row bands column by column into the line buffer and writes each output pixel.
module bnn_conv_sequencer #(
  parameter int ADDR_W = 5,
  parameter int K      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  bnn_conv_sequencer_if.master  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CONV, DRAIN1, DRAIN2, DONE} state_t;

  localparam logic [ADDR_W:0]   K_EXT = (ADDR_W + 1)'(K);
  localparam logic [ADDR_W-1:0] K_A   = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] KM1_A = ADDR_W'(K - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] rows_q, rows_d, cols_q, cols_d;
  logic              err_q, err_d;
  logic              buf_q, buf_d;
  logic              wr1_q, wr1_d, wr2_q, wr2_d;
  logic [ADDR_W-1:0] wr1_row_q, wr1_row_d, wr1_col_q, wr1_col_d;
  logic [ADDR_W-1:0] wr2_row_q, wr2_row_d, wr2_col_q, wr2_col_d;
  logic              cfg_bad;

  assign cfg_bad = ({1'b0, bus.cfg_rows} < K_EXT) || ({1'b0, bus.cfg_cols} < K_EXT);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          rows_d  = bus.cfg_rows;
          cols_d  = bus.cfg_cols;
          row_d   = '0;
          col_d   = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: if (bus.in_valid) begin
        if (col_q == cols_q - 1'b1) begin
          col_d = '0;
          if (row_q == rows_q - 1'b1) begin
            row_d   = '0;
            state_d = CONV;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      CONV: begin
        if (col_q == cols_q - 1'b1) state_d = DRAIN1;
        else                         col_d   = col_q + 1'b1;
      end
      DRAIN1: state_d = DRAIN2;
      DRAIN2: begin
        col_d = '0;
        if (row_q == rows_q - K_A) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = CONV;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read -> buffer shift -> output write pipeline; the first K-1 columns of a
  // band produce no write, which hides whatever the previous band left behind.
  always_comb begin
    buf_d     = (state_q == CONV);
    wr1_d     = (state_q == CONV) && (col_q >= KM1_A);
    wr1_row_d = row_q;
    wr1_col_d = col_q - KM1_A;
    wr2_d     = wr1_q;
    wr2_row_d = wr1_row_q;
    wr2_col_d = wr1_col_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      err_q     <= 1'b0;
      buf_q     <= 1'b0;
      wr1_q     <= 1'b0;
      wr2_q     <= 1'b0;
      wr1_row_q <= '0;
      wr1_col_q <= '0;
      wr2_row_q <= '0;
      wr2_col_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      err_q     <= err_d;
      buf_q     <= buf_d;
      wr1_q     <= wr1_d;
      wr2_q     <= wr2_d;
      wr1_row_q <= wr1_row_d;
      wr1_col_q <= wr1_col_d;
      wr2_row_q <= wr2_row_d;
      wr2_col_q <= wr2_col_d;
    end
  end

  always_comb begin
    bus.inmem_en  = 1'b0;
    bus.inmem_rw  = 1'b0;
    bus.inmem_row = '0;
    bus.inmem_col = '0;
    if (state_q == LOAD) begin
      bus.inmem_en  = bus.in_valid;
      bus.inmem_rw  = bus.in_valid;
      bus.inmem_row = row_q;
      bus.inmem_col = col_q;
    end else if (state_q == CONV) begin
      bus.inmem_en  = 1'b1;
      bus.inmem_row = row_q;
      bus.inmem_col = col_q;
    end
  end

  // Host readback shares the output port; it only exists in IDLE, when the write pipe is empty.
  always_comb begin
    bus.outmem_en  = 1'b0;
    bus.outmem_rw  = 1'b0;
    bus.outmem_row = '0;
    bus.outmem_col = '0;
    if (state_q == IDLE && bus.rd_en) begin
      bus.outmem_en  = 1'b1;
      bus.outmem_row = bus.rd_row;
      bus.outmem_col = bus.rd_col;
    end else if (wr2_q) begin
      bus.outmem_en  = 1'b1;
      bus.outmem_rw  = 1'b1;
      bus.outmem_row = wr2_row_q;
      bus.outmem_col = wr2_col_q;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.buffer_en = buf_q;
  assign bus.busy      = (state_q == LOAD) || (state_q == CONV) ||
                         (state_q == DRAIN1) || (state_q == DRAIN2);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bnn_conv_sequencer.sv
// Scoreboard bench: each job pushes its expected memory traffic into queues and
// an independent monitor pops and compares whenever the sequencer drives a memory.
module tb_bnn_conv_sequencer;
  localparam int AW = 5;
  localparam int KK = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_conv_sequencer_if #(.ADDR_W(AW)) bus ();

  bnn_conv_sequencer #(.ADDR_W(AW), .K(KK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*AW-1:0] q_inwr[$];
  logic [2*AW-1:0] q_rd[$];
  logic [2*AW-1:0] q_owr[$];
  int  buf_cnt = 0, done_cnt = 0, first_buf_cyc = 0, done_cyc = 0;
  bit  mon_en = 0, exp_err = 0, saw_read = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: consumes expected traffic in order of appearance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.inmem_en && bus.inmem_rw) begin
        check("inmem_wr_expected", q_inwr.size() != 0, 1);
        if (q_inwr.size() != 0) check("inmem_wr_addr", {bus.inmem_row, bus.inmem_col}, q_inwr.pop_front());
      end
      if (bus.inmem_en && !bus.inmem_rw) begin
        saw_read = 1;
        check("inmem_rd_expected", q_rd.size() != 0, 1);
        if (q_rd.size() != 0) check("inmem_rd_addr", {bus.inmem_row, bus.inmem_col}, q_rd.pop_front());
      end
      if (bus.outmem_en && bus.outmem_rw) begin
        check("outmem_wr_expected", q_owr.size() != 0, 1);
        if (q_owr.size() != 0) check("outmem_wr_addr", {bus.outmem_row, bus.outmem_col}, q_owr.pop_front());
      end
      if (bus.busy && bus.outmem_en && !bus.outmem_rw) check("outmem_rd_while_busy", 1'b1, 1'b0);
      if (bus.buffer_en) begin
        if (buf_cnt == 0) first_buf_cyc = cyc;
        buf_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("err_at_done", bus.err, exp_err);
      end
    end
  end

  // Expected traffic straight from the job definition: raster load, K-row band
  // sweeps, and one output write per valid window position.
  task automatic push_expect(input int r_n, input int c_n);
    for (int r = 0; r < r_n; r++)
      for (int c = 0; c < c_n; c++) q_inwr.push_back({AW'(r), AW'(c)});
    for (int b = 0; b <= r_n - KK; b++) begin
      for (int c = 0; c < c_n; c++) q_rd.push_back({AW'(b), AW'(c)});
      for (int c = 0; c <= c_n - KK; c++) q_owr.push_back({AW'(b), AW'(c)});
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {bus.in_ready, bus.inmem_en, bus.inmem_rw, bus.inmem_row, bus.inmem_col,
            bus.buffer_en, bus.outmem_en, bus.outmem_rw, bus.outmem_row, bus.outmem_col,
            bus.busy, bus.done, bus.err};
  endfunction

  // mode: 0 continuous in_valid, 1 toggling, 2 random
  task automatic run_job(input int r_n, input int c_n, input int mode, input bit poke_start);
    bit bad;
    int s, d0, n;
    bit poked;
    bad = (r_n < KK) || (c_n < KK);
    if (!bad) push_expect(r_n, c_n);
    exp_err = bad;
    buf_cnt = 0;
    saw_read = 0;
    poked = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cfg_rows = AW'(r_n);
    bus.cfg_cols = AW'(c_n);
    bus.start = 1'b1;
    bus.rd_en = 1'b0;
    s = cyc;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (poke_start && saw_read && !poked) begin
        bus.start = 1'b1;
        bus.cfg_rows = AW'(KK);
        bus.cfg_cols = AW'(KK);
        poked = 1;
      end
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = n[0];
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.rd_en  = 1'($urandom_range(0, 1));
      bus.rd_row = AW'($urandom_range(0, 31));
      bus.rd_col = AW'($urandom_range(0, 31));
      n++;
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("inmem_wr_left", q_inwr.size(), 0);
    check("inmem_rd_left", q_rd.size(), 0);
    check("outmem_wr_left", q_owr.size(), 0);
    check("buffer_en_count", buf_cnt, bad ? 0 : (r_n - KK + 1) * c_n);
    check("err_held", bus.err, bad);
    check("busy_idle", bus.busy, 0);
    if (bad)
      check("done_latency", done_cyc - s, 1);
    else if (mode == 0) begin
      check("first_buffer_en_latency", first_buf_cyc - s, r_n * c_n + 2);
      check("done_latency", done_cyc - s, r_n * c_n + (r_n - KK + 1) * (c_n + 2) + 1);
    end
    $display("job %0dx%0d mode %0d: err=%0b buffer_en=%0d done_at=+%0d", r_n, c_n, mode, bus.err, buf_cnt, done_cyc - s);
    q_inwr.delete(); q_rd.delete(); q_owr.delete();
  endtask

  task automatic readback(input int r, input int c);
    @(posedge clk); #1;
    bus.rd_en = 1'b1;
    bus.rd_row = AW'(r);
    bus.rd_col = AW'(c);
    @(negedge clk);
    check("readback", {bus.outmem_en, bus.outmem_rw, bus.outmem_row, bus.outmem_col},
          {1'b1, 1'b0, AW'(r), AW'(c)});
    $display("readback (%0d,%0d): en=%0b rw=%0b", r, c, bus.outmem_en, bus.outmem_rw);
    #1 bus.rd_en = 1'b0;
  endtask

  task automatic reset_mid_conv();
    int n;
    push_expect(KK, KK);
    exp_err = 0;
    saw_read = 0;
    @(posedge clk); #1;
    bus.cfg_rows = AW'(KK);
    bus.cfg_cols = AW'(KK);
    bus.start = 1'b1;
    n = 0;
    while (!saw_read && n < 200) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      n++;
    end
    check("reached_conv", saw_read, 1);
    @(posedge clk); #1;
    mon_en = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_conv_outputs", all_outputs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset mid-CONV: outputs=%0h", all_outputs());
    q_inwr.delete(); q_rd.delete(); q_owr.delete();
    mon_en = 1;
    repeat (4) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_rows = '0;
    bus.cfg_cols = '0;
    bus.in_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    $display("reset: outputs=%0h", all_outputs());
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;
    repeat (5) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;

    run_job(5, 5, 0, 0);
    readback(0, 0);
    run_job(7, 6, 0, 1);
    run_job(5, 5, 1, 0);
    run_job(4, 8, 0, 0);
    readback(3, 7);
    reset_mid_conv();
    run_job(5, 5, 0, 0);
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(3, 10), $urandom_range(3, 10), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      readback($urandom_range(0, 31), $urandom_range(0, 31));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
